// File: rtl/tmds_encoder.sv
// Single-channel DVI 1.0 TMDS 8b/10b encoder with running-disparity DC balancing.
// The pipeline has three register stages: input capture, transition-minimised word, then symbol and disparity.
module tmds_encoder #(
  parameter logic [9:0] DOUT_RST = 10'b1101010100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] dout,
  output logic [4:0] disp
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  // Stage 1 registers
  logic [7:0] din_s1_q;
  logic [3:0] n1d_s1_q;
  logic       de_s1_q, c0_s1_q, c1_s1_q;

  // Stage 2 registers
  logic [8:0] q_m_q;
  logic [8:0] q_m_d;
  logic       de_s2_q, c0_s2_q, c1_s2_q;
  logic       use_xnor;

  // Stage 3 registers
  logic [9:0]        dout_q, dout_d;
  logic signed [4:0] cnt_q, cnt_d;

  always_comb begin
    q_m_d    = '0;
    use_xnor = (n1d_s1_q > 4'd4) || ((n1d_s1_q == 4'd4) && !din_s1_q[0]);
    q_m_d[0] = din_s1_q[0];
    for (int i = 1; i < 8; i++) begin
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ din_s1_q[i]) : (q_m_d[i-1] ^ din_s1_q[i]);
    end
    q_m_d[8] = ~use_xnor;
  end

  logic [3:0]        n1q, n0q;
  logic signed [4:0] n1s, n0s, diff;
  logic              q8;

  always_comb begin
    n1q    = popcount8(q_m_q[7:0]);
    n0q    = 4'd8 - n1q;
    n1s    = $signed({1'b0, n1q});
    n0s    = $signed({1'b0, n0q});
    diff   = n1s - n0s;
    q8     = q_m_q[8];
    dout_d = DOUT_RST;
    cnt_d  = cnt_q;
    if (!de_s2_q) begin
      // Blanking always restarts the disparity from zero for the next active span.
      cnt_d = 5'sd0;
      case ({c1_s2_q, c0_s2_q})
        2'b00:   dout_d = 10'b1101010100;
        2'b01:   dout_d = 10'b0010101011;
        2'b10:   dout_d = 10'b0101010100;
        default: dout_d = 10'b1010101011;
      endcase
    end else if ((cnt_q == 5'sd0) || (n1q == n0q)) begin
      dout_d = {~q8, q8, (q8 ? q_m_q[7:0] : ~q_m_q[7:0])};
      cnt_d  = cnt_q + (q8 ? diff : -diff);
    end else if (((cnt_q > 5'sd0) && (n1q > n0q)) || ((cnt_q < 5'sd0) && (n0q > n1q))) begin
      dout_d = {1'b1, q8, ~q_m_q[7:0]};
      cnt_d  = cnt_q + (q8 ? 5'sd2 : 5'sd0) - diff;
    end else begin
      dout_d = {1'b0, q8, q_m_q[7:0]};
      cnt_d  = cnt_q + diff - (q8 ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_s1_q <= '0;
      n1d_s1_q <= '0;
      de_s1_q  <= 1'b0;
      c0_s1_q  <= 1'b0;
      c1_s1_q  <= 1'b0;
      q_m_q    <= '0;
      de_s2_q  <= 1'b0;
      c0_s2_q  <= 1'b0;
      c1_s2_q  <= 1'b0;
      dout_q   <= DOUT_RST;
      cnt_q    <= 5'sd0;
    end else begin
      din_s1_q <= din;
      n1d_s1_q <= popcount8(din);
      de_s1_q  <= de;
      c0_s1_q  <= c0;
      c1_s1_q  <= c1;
      q_m_q    <= q_m_d;
      de_s2_q  <= de_s1_q;
      c0_s2_q  <= c0_s1_q;
      c1_s2_q  <= c1_s1_q;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = dout_q;
  assign disp = cnt_q;

endmodule
